// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle ops land in C one edge after accept; signed MUL (radix-2 Booth)
// and DIV (non-restoring on magnitudes) iterate WIDTH cycles. Result is HI:LO in a 2*WIDTH register.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic [4:0]           opcode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   C,
  output logic                 div_by_zero
);
  localparam logic [4:0] OP_ADD = 5'b00011, OP_SUB = 5'b00100, OP_MUL = 5'b10000, OP_DIV = 5'b01111,
                         OP_SHR = 5'b01001, OP_SHL = 5'b01011, OP_SHRA = 5'b01010, OP_ROR = 5'b00111,
                         OP_ROL = 5'b01000, OP_AND = 5'b00101, OP_OR = 5'b00110, OP_NEG = 5'b10001,
                         OP_XOR = 5'b01101, OP_NOR = 5'b01110, OP_NOT = 5'b10010;
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH-1);

  typedef enum logic [1:0] {S_IDLE, S_DONE, S_MUL, S_DIV} state_t;

  state_t               r_state, w_next;
  logic [SHW:0]         r_cnt;
  logic [WIDTH:0]       r_acc;
  logic [WIDTH+1:0]     r_rem;
  logic [WIDTH-1:0]     r_q, r_m, r_a;
  logic                 r_qm1, r_dz, r_negq, r_negr, r_dbz;
  logic [2*WIDTH-1:0]   r_c;

  logic                 w_accept, w_last, w_sext;
  logic [SHW-1:0]       w_sh, w_nsh;
  logic [WIDTH-1:0]     w_lo, w_amag, w_bmag, w_qn, w_rmag, w_dq, w_dr;
  logic [2*WIDTH-1:0]   w_alu;
  logic [WIDTH:0]       w_msx, w_sum;
  logic [WIDTH+1:0]     w_shr, w_rn;

  assign ready       = (r_state == S_IDLE) || (r_state == S_DONE);
  assign busy        = (r_state == S_MUL)  || (r_state == S_DIV);
  assign done        = (r_state == S_DONE);
  assign C           = r_c;
  assign div_by_zero = r_dbz;
  assign w_accept    = start && ready;
  assign w_last      = (r_cnt == CNT_LAST);

  // Rotates use the negated amount so a zero amount needs no special case.
  assign w_sh  = B[SHW-1:0];
  assign w_nsh = SHW'(0) - w_sh;

  always_comb begin
    w_lo   = '0;
    w_sext = 1'b0;
    case (opcode)
      OP_ADD:  begin w_lo = A + B;         w_sext = 1'b1; end
      OP_SUB:  begin w_lo = A - B;         w_sext = 1'b1; end
      OP_NEG:  begin w_lo = WIDTH'(0) - A; w_sext = 1'b1; end
      OP_AND:  w_lo = A & B;
      OP_OR:   w_lo = A | B;
      OP_XOR:  w_lo = A ^ B;
      OP_NOR:  w_lo = ~(A | B);
      OP_NOT:  w_lo = ~A;
      OP_SHR:  w_lo = A >> w_sh;
      OP_SHL:  w_lo = A << w_sh;
      OP_SHRA: w_lo = $signed(A) >>> w_sh;
      OP_ROR:  w_lo = (A >> w_sh) | (A << w_nsh);
      OP_ROL:  w_lo = (A << w_sh) | (A >> w_nsh);
      default: w_lo = '0;
    endcase
    w_alu = {(w_sext ? {WIDTH{w_lo[WIDTH-1]}} : {WIDTH{1'b0}}), w_lo};
  end

  // Booth step: W+1-bit partial sum keeps the most-negative square exact.
  assign w_msx = {r_m[WIDTH-1], r_m};
  always_comb begin
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + w_msx;
      2'b10:   w_sum = r_acc - w_msx;
      default: w_sum = r_acc;
    endcase
  end

  // Non-restoring divide on magnitudes; signs applied at the end.
  assign w_amag = A[WIDTH-1] ? WIDTH'(0) - A : A;
  assign w_bmag = B[WIDTH-1] ? WIDTH'(0) - B : B;
  assign w_shr  = {r_rem[WIDTH:0], r_q[WIDTH-1]};
  assign w_rn   = r_rem[WIDTH+1] ? w_shr + {2'b00, r_m} : w_shr - {2'b00, r_m};
  assign w_qn   = {r_q[WIDTH-2:0], ~w_rn[WIDTH+1]};
  assign w_rmag = w_rn[WIDTH+1] ? w_rn[WIDTH-1:0] + r_m : w_rn[WIDTH-1:0];
  assign w_dq   = r_negq ? WIDTH'(0) - w_qn   : w_qn;
  assign w_dr   = r_negr ? WIDTH'(0) - w_rmag : w_rmag;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (opcode == OP_MUL)      w_next = S_MUL;
          else if (opcode == OP_DIV) w_next = S_DIV;
          else                       w_next = S_DONE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_MUL, S_DIV: if (w_last) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_a     <= '0;
      r_qm1   <= 1'b0;
      r_dz    <= 1'b0;
      r_negq  <= 1'b0;
      r_negr  <= 1'b0;
      r_dbz   <= 1'b0;
      r_c     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_DONE: if (w_accept) begin
          r_cnt  <= '0;
          r_acc  <= '0;
          r_rem  <= '0;
          r_qm1  <= 1'b0;
          r_a    <= A;
          r_dz   <= (B == '0);
          r_negq <= A[WIDTH-1] ^ B[WIDTH-1];
          r_negr <= A[WIDTH-1];
          if (opcode == OP_DIV) begin
            r_q <= w_amag;
            r_m <= w_bmag;
          end else begin
            r_q <= B;
            r_m <= A;
          end
          if (opcode != OP_MUL && opcode != OP_DIV) begin
            r_c   <= w_alu;
            r_dbz <= 1'b0;
          end
        end
        S_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= {w_sum[WIDTH], w_sum[WIDTH:1]};
          r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          r_qm1 <= r_q[0];
          if (w_last) begin
            r_c   <= {w_sum, r_q[WIDTH-1:1]};
            r_dbz <= 1'b0;
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          r_rem <= w_rn;
          r_q   <= w_qn;
          if (w_last) begin
            r_c   <= r_dz ? {r_a, {WIDTH{1'b1}}} : {w_dr, w_dq};
            r_dbz <= r_dz;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: stimulus pushes expected results, per-DUT monitors pop on done.
module tb_seq_alu;
  localparam logic [4:0] ADD = 5'b00011, SUB = 5'b00100, MUL = 5'b10000, DIV = 5'b01111,
                         SHR = 5'b01001, SHL = 5'b01011, SHRA = 5'b01010, ROR = 5'b00111,
                         ROL = 5'b01000, AND = 5'b00101, OR = 5'b00110, NEG = 5'b10001,
                         XOR = 5'b01101, NOR = 5'b01110, NOT = 5'b10010, NOP = 5'b11010;

  logic        clock = 1'b0, clear = 1'b0;
  logic        start = 1'b0, start8 = 1'b0;
  logic [4:0]  opcode = '0, opcode8 = '0;
  logic [31:0] A = '0, B = '0;
  logic [7:0]  A8 = '0, B8 = '0;
  logic        ready, busy, done, dbz, ready8, busy8, done8, dbz8;
  logic [63:0] C;
  logic [15:0] C8;

  typedef struct {string nm; logic [63:0] c; logic dz; int cyc;} exp_t;
  exp_t q32[$];
  exp_t q8[$];
  int   n_tests = 0, n_fail = 0, cyc = 0;

  seq_alu #(.WIDTH(32)) dut (.clock(clock), .clear(clear), .start(start), .opcode(opcode), .A(A), .B(B),
    .ready(ready), .busy(busy), .done(done), .C(C), .div_by_zero(dbz));
  seq_alu #(.WIDTH(8)) dut8 (.clock(clock), .clear(clear), .start(start8), .opcode(opcode8), .A(A8), .B(B8),
    .ready(ready8), .busy(busy8), .done(done8), .C(C8), .div_by_zero(dbz8));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (clear && done) begin
      if (q32.size() == 0) chk("unexpected_done32", 64'd1, 64'd0);
      else begin
        e = q32.pop_front();
        chk({e.nm, "_C"}, C, e.c);
        chk({e.nm, "_dbz"}, {63'd0, dbz}, {63'd0, e.dz});
        chk({e.nm, "_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (clear && done8) begin
      if (q8.size() == 0) chk("unexpected_done8", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        chk({e.nm, "_C"}, {48'd0, C8}, e.c);
        chk({e.nm, "_dbz"}, {63'd0, dbz8}, {63'd0, e.dz});
        chk({e.nm, "_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Called at a negedge; the accept edge is the next posedge. Inputs are scrambled afterwards.
  task automatic issue(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] c, input logic dz, input bit push);
    int lat;
    lat = (op == MUL || op == DIV) ? 32 : 0;
    if (push) q32.push_back('{nm, c, dz, cyc + 1 + lat});
    opcode = op; A = a; B = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_5679; opcode = ADD;
  endtask

  task automatic issue8(input string nm, input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] c, input logic dz);
    int lat;
    lat = (op == MUL || op == DIV) ? 8 : 0;
    q8.push_back('{nm, {48'd0, c}, dz, cyc + 1 + lat});
    opcode8 = op; A8 = a; B8 = b; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0; A8 = 8'h5A; B8 = 8'h3C;
  endtask

  task automatic drain();
    int t = 0;
    while ((q32.size() != 0 || q8.size() != 0) && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (q32.size() != 0 || q8.size() != 0) begin
      chk("drain_timeout", 64'(q32.size() + q8.size()), 64'd0);
      q32.delete();
      q8.delete();
    end
    @(negedge clock);
  endtask

  initial begin
    int bad;
    #7;
    chk("rst_C", C, 64'd0);
    chk("rst_flags", {60'd0, done, busy, dbz, ready}, 64'd1);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    chk("rst_ready", {63'd0, ready}, 64'd1);

    issue("add", ADD, 32'd7, 32'hFFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1); drain();
    issue("sub_zero", SUB, 32'd5, 32'd5, 64'd0, 1'b0, 1); drain();
    issue("sub_wrap", SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b0, 1); drain();
    issue("and", AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0000_0000_00F0_00F0, 1'b0, 1); drain();
    issue("or", OR, 32'hF000_0000, 32'd1, 64'h0000_0000_F000_0001, 1'b0, 1); drain();
    issue("xor", XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 64'h0000_0000_F0F0_0F0F, 1'b0, 1); drain();
    issue("nor", NOR, 32'hF0F0_F0F0, 32'h0000_FFFF, 64'h0000_0000_0F0F_0000, 1'b0, 1); drain();
    issue("not", NOT, 32'h1234_5678, 32'hFFFF_FFFF, 64'h0000_0000_EDCB_A987, 1'b0, 1); drain();
    issue("neg", NEG, 32'd5, 32'd9, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1); drain();
    issue("neg_min", NEG, 32'h8000_0000, 32'd0, 64'hFFFF_FFFF_8000_0000, 1'b0, 1); drain();
    issue("shl31", SHL, 32'd1, 32'd31, 64'h0000_0000_8000_0000, 1'b0, 1); drain();
    issue("shr_amt0", SHR, 32'h8000_0000, 32'h20, 64'h0000_0000_8000_0000, 1'b0, 1); drain();
    issue("shr4", SHR, 32'hF000_0000, 32'd4, 64'h0000_0000_0F00_0000, 1'b0, 1); drain();
    issue("shra", SHRA, 32'h8000_0000, 32'd36, 64'h0000_0000_F800_0000, 1'b0, 1); drain();
    issue("ror", ROR, 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000, 1'b0, 1); drain();
    issue("rol", ROL, 32'h8000_0001, 32'd4, 64'h0000_0000_0000_0018, 1'b0, 1); drain();
    issue("nop", NOP, 32'h1111_1111, 32'h2222_2222, 64'd0, 1'b0, 1); drain();
    issue("undef", 5'b11111, 32'h1111_1111, 32'h2222_2222, 64'd0, 1'b0, 1); drain();

    // Busy window of a multiply, with a different request held while busy.
    issue("mul_neg", MUL, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1);
    opcode = ADD; A = 32'd5; B = 32'd6; start = 1'b1;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (!(busy && !ready)) bad++;
      if (i == 10) start = 1'b0;
      if (i < 31) @(negedge clock);
    end
    chk("mul_busy_window", 64'(bad), 64'd0);
    drain();
    issue("mul_min_sq", MUL, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1); drain();
    issue("mul_max_sq", MUL, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 1'b0, 1); drain();
    issue("div_neg", DIV, 32'hFFFF_FFEF, 32'd5, {32'hFFFF_FFFE, 32'hFFFF_FFFD}, 1'b0, 1); drain();
    issue("div_negb", DIV, 32'd17, 32'hFFFF_FFFB, {32'h0000_0002, 32'hFFFF_FFFD}, 1'b0, 1); drain();
    issue("div_zero", DIV, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF}, 1'b1, 1); drain();
    issue("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b0, 1); drain();

    // Back-to-back: the second request is accepted in the DONE cycle of the first.
    issue("b2b_1", ADD, 32'd1, 32'd2, 64'd3, 1'b0, 1);
    issue("b2b_2", XOR, 32'hFF, 32'h0F, 64'h0000_0000_0000_00F0, 1'b0, 1);
    drain();

    // Reset during a divide discards it.
    issue("div_killed", DIV, 32'd1000, 32'd7, 64'd0, 1'b0, 0);
    repeat (9) @(negedge clock);
    clear = 1'b0;
    #1;
    chk("midrst_C", C, 64'd0);
    chk("midrst_flags", {61'd0, done, busy, dbz}, 64'd0);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    chk("midrst_ready", {63'd0, ready}, 64'd1);
    repeat (40) @(negedge clock);

    issue8("w8_mul", MUL, 8'h80, 8'h80, 16'h4000, 1'b0); drain();
    issue8("w8_div", DIV, 8'h81, 8'h07, {8'hFF, 8'hEE}, 1'b0); drain();
    issue8("w8_divz", DIV, 8'h05, 8'h00, {8'h05, 8'hFF}, 1'b1); drain();

    repeat (5) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
